tank_motion_ctrl: RTL and testbench

- Per-frame state controller for one tank. It owns heading, position and the sin/cos operands consumed by the pixel-rotation color mapper.
- On each frame_clk rising edge it runs a short multi-cycle update sequence: rotate, trig lookup, move, clamp/commit.
- It outputs a stable TankX/TankY/sin_out/cos_out for the whole following frame.
- Two instances are used in the top level, one per player.

---
 rtl/tank_motion_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tank_motion_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tank_motion_ctrl.sv
// Per-frame tank controller: rotate, trig lookup, move, clamp/commit on each frame_clk rise.
// Optional macro TANK_COLLIDE_EN adds wall_hit, which discards the candidate position in CLAMP.
module tank_motion_ctrl #(
  parameter int X_INIT  = 160,
  parameter int Y_INIT  = 240,
  parameter int X_MIN   = 8,
  parameter int X_MAX   = 631,
  parameter int Y_MIN   = 8,
  parameter int Y_MAX   = 471,
  parameter int SPEED   = 32,
  parameter int ROT_DIV = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              rot_left,
  input  logic              rot_right,
  input  logic              fwd,
  input  logic              back,
`ifdef TANK_COLLIDE_EN
  input  logic              wall_hit,
`endif
  output logic [9:0]        TankX,
  output logic [9:0]        TankY,
  output logic [5:0]        angle,
  output logic signed [7:0] sin_out,
  output logic signed [7:0] cos_out,
  output logic              upd_done
);

  localparam int CNT_W = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam logic signed [15:0] SPEED_S = 16'(SPEED);
  localparam logic signed [15:0] X_LO = 16'(X_MIN * 16);
  localparam logic signed [15:0] X_HI = 16'(X_MAX * 16);
  localparam logic signed [15:0] Y_LO = 16'(Y_MIN * 16);
  localparam logic signed [15:0] Y_HI = 16'(Y_MAX * 16);

  typedef enum logic [2:0] {S_IDLE, S_ROTATE, S_LOOKUP, S_MOVE, S_CLAMP} state_t;

  state_t                   state_q;
  logic                     frame_prev_q;
  logic [CNT_W-1:0]         rot_cnt_q;
  logic [5:0]               ang_q;
  logic signed [7:0]        sin_q, cos_q;
  logic [13:0]              pos_x_q, pos_y_q;
  logic signed [15:0]       cand_x_q, cand_y_q;

  logic                     frame_edge, rl, rr, hit;
  logic signed [7:0]        sin_d, cos_d;
  logic signed [15:0]       sin_ext, cos_ext, prod_sin, prod_cos;
  logic signed [15:0]       dx_d, dy_d, cand_x_d, cand_y_d;
  logic [13:0]              commit_x_d, commit_y_d;

  // Quarter-wave table folded into a full 64-step circle, Q1.6.
  function automatic logic signed [7:0] trig_sin(input logic [5:0] a);
    logic [4:0] k;
    logic [6:0] mag;
    k = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
    case (k)
      5'd0:    mag = 7'd0;
      5'd1:    mag = 7'd6;
      5'd2:    mag = 7'd12;
      5'd3:    mag = 7'd19;
      5'd4:    mag = 7'd24;
      5'd5:    mag = 7'd30;
      5'd6:    mag = 7'd36;
      5'd7:    mag = 7'd41;
      5'd8:    mag = 7'd45;
      5'd9:    mag = 7'd49;
      5'd10:   mag = 7'd53;
      5'd11:   mag = 7'd56;
      5'd12:   mag = 7'd59;
      5'd13:   mag = 7'd61;
      5'd14:   mag = 7'd63;
      default: mag = 7'd64;
    endcase
    return a[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [13:0] clamp_axis(input logic signed [15:0] v,
                                             input logic signed [15:0] lo,
                                             input logic signed [15:0] hi);
    logic signed [15:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[13:0];
  endfunction

  assign frame_edge = frame_clk & ~frame_prev_q;
  assign rl = rot_left & ~rot_right;
  assign rr = rot_right & ~rot_left;
  assign sin_d = trig_sin(ang_q);
  assign cos_d = trig_sin(ang_q + 6'd16);

  assign sin_ext  = {{8{sin_q[7]}}, sin_q};
  assign cos_ext  = {{8{cos_q[7]}}, cos_q};
  assign prod_sin = sin_ext * SPEED_S;
  assign prod_cos = cos_ext * SPEED_S;

  // Screen Y grows downward, so moving along heading 0 (up) decreases Y.
  always_comb begin
    dx_d = '0;
    dy_d = '0;
    if (fwd & ~back) begin
      dx_d = prod_sin >>> 6;
      dy_d = (-prod_cos) >>> 6;
    end else if (back & ~fwd) begin
      dx_d = (-prod_sin) >>> 6;
      dy_d = prod_cos >>> 6;
    end
  end

  assign cand_x_d = $signed({2'b00, pos_x_q}) + dx_d;
  assign cand_y_d = $signed({2'b00, pos_y_q}) + dy_d;

`ifdef TANK_COLLIDE_EN
  assign hit = wall_hit;
`else
  assign hit = 1'b0;
`endif

  assign commit_x_d = hit ? pos_x_q : clamp_axis(cand_x_q, X_LO, X_HI);
  assign commit_y_d = hit ? pos_y_q : clamp_axis(cand_y_q, Y_LO, Y_HI);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b1;
      rot_cnt_q    <= '0;
      ang_q        <= '0;
      sin_q        <= 8'sd0;
      cos_q        <= 8'sd64;
      pos_x_q      <= 14'(X_INIT * 16);
      pos_y_q      <= 14'(Y_INIT * 16);
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      TankX        <= 10'(X_INIT);
      TankY        <= 10'(Y_INIT);
      angle        <= '0;
      sin_out      <= 8'sd0;
      cos_out      <= 8'sd64;
      upd_done     <= 1'b0;
    end else begin
      frame_prev_q <= frame_clk;
      upd_done     <= 1'b0;
      case (state_q)
        S_IDLE: if (frame_edge) state_q <= S_ROTATE;
        S_ROTATE: begin
          if (!(rl | rr)) begin
            rot_cnt_q <= '0;
          end else if (rot_cnt_q == CNT_W'(ROT_DIV - 1)) begin
            ang_q     <= rl ? ang_q - 6'd1 : ang_q + 6'd1;
            rot_cnt_q <= '0;
          end else begin
            rot_cnt_q <= rot_cnt_q + 1'b1;
          end
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          sin_q   <= sin_d;
          cos_q   <= cos_d;
          state_q <= S_MOVE;
        end
        S_MOVE: begin
          cand_x_q <= cand_x_d;
          cand_y_q <= cand_y_d;
          state_q  <= S_CLAMP;
        end
        S_CLAMP: begin
          pos_x_q  <= commit_x_d;
          pos_y_q  <= commit_y_d;
          TankX    <= commit_x_d[13:4];
          TankY    <= commit_y_d[13:4];
          angle    <= ang_q;
          sin_out  <= sin_q;
          cos_out  <= cos_q;
          upd_done <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed-vector bench for tank_motion_ctrl: frame table plus hand sequences for clamp and reset abort.
module tb_tank_motion_ctrl;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              frame_clk = 1'b0;
  logic              rot_left = 1'b0, rot_right = 1'b0, fwd = 1'b0, back = 1'b0;
`ifdef TANK_COLLIDE_EN
  logic              wall_hit = 1'b0;
`endif
  logic [9:0]        TankX, TankY;
  logic [5:0]        angle;
  logic signed [7:0] sin_out, cos_out;
  logic              upd_done;

  int checks = 0;
  int errors = 0;

  tank_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .rot_left(rot_left), .rot_right(rot_right), .fwd(fwd), .back(back),
`ifdef TANK_COLLIDE_EN
    .wall_hit(wall_hit),
`endif
    .TankX(TankX), .TankY(TankY), .angle(angle),
    .sin_out(sin_out), .cos_out(cos_out), .upd_done(upd_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rl, rr, fw, bk;
    int   x, y, ang, sn, cs;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int x, input int y,
                               input int ang, input int sn, input int cs);
    check({tag, " TankX"}, int'(TankX), x);
    check({tag, " TankY"}, int'(TankY), y);
    check({tag, " angle"}, int'(angle), ang);
    check({tag, " sin_out"}, int'(sin_out), sn);
    check({tag, " cos_out"}, int'(cos_out), cs);
  endtask

  // One frame: raise frame_clk, time the commit, then confirm upd_done is a single-cycle pulse.
  task automatic do_frame(input logic rl, input logic rr, input logic fw, input logic bk);
    int lat;
    rot_left = rl; rot_right = rr; fwd = fw; back = bk;
    @(negedge Clk);
    frame_clk = 1'b1;
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      @(posedge Clk); #1;
      if (n == 0) frame_clk = 1'b0;
      if (upd_done) begin
        lat = n;
        break;
      end
    end
    check("commit latency", lat, 4);
    @(posedge Clk); #1;
    check("upd_done pulse width", int'(upd_done), 0);
    rot_left = 1'b0; rot_right = 1'b0; fwd = 1'b0; back = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int exp_x;
    //          rl    rr    fw    bk     x    y   ang  sin  cos
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240,  0,   0, 64};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240,  1,   6, 64};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240,  1,   6, 64};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240,  2,  12, 63};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240,  2,  12, 63};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240,  1,   6, 64};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240,  1,   6, 64};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240,  0,   0, 64};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240,  0,   0, 64};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 240, 63,  -6, 64};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240, 63,  -6, 64};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 160, 240,  0,   0, 64};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 160, 238,  0,   0, 64};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 160, 236,  0,   0, 64};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 160, 234,  0,   0, 64};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1,   8, 234, 16,  64,  0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1,   8, 234, 16,  64,  0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1,   8, 234, 16,  64,  0};

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (upd_done) seen++;
    end
    check_outputs("reset", 160, 240, 0, 0, 64);
    check("reset upd_done count", seen, 0);
    $display("reset: TankX=%0d TankY=%0d angle=%0d", TankX, TankY, angle);

    // Rotation wrap and forward motion at heading 0.
    for (int i = 0; i <= 14; i++) begin
      do_frame(tbl[i].rl, tbl[i].rr, tbl[i].fw, tbl[i].bk);
      check_outputs($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].ang, tbl[i].sn, tbl[i].cs);
      $display("vec%0d: TankX=%0d TankY=%0d angle=%0d sin=%0d cos=%0d",
               i, TankX, TankY, angle, sin_out, cos_out);
    end

    // Turn to heading 16 (facing right): 32 frames at two frames per step.
    for (int i = 0; i < 32; i++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_outputs("heading16", 160, 234, 16, 64, 0);
    $display("heading16: angle=%0d sin=%0d cos=%0d", angle, sin_out, cos_out);

    // Reverse toward the left wall, 2 px per frame, until clamped at X_MIN.
    for (int n = 1; n <= 78; n++) begin
      do_frame(1'b0, 1'b0, 1'b0, 1'b1);
      exp_x = (160 - 2 * n < 8) ? 8 : 160 - 2 * n;
      check($sformatf("back%0d TankX", n), int'(TankX), exp_x);
      check($sformatf("back%0d TankY", n), int'(TankY), 234);
      $display("back%0d: TankX=%0d TankY=%0d", n, TankX, TankY);
    end

    // Conflicting keys on every axis: nothing moves, commit still pulses.
    for (int i = 15; i <= 17; i++) begin
      do_frame(tbl[i].rl, tbl[i].rr, tbl[i].fw, tbl[i].bk);
      check_outputs($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].ang, tbl[i].sn, tbl[i].cs);
      $display("vec%0d: TankX=%0d TankY=%0d angle=%0d", i, TankX, TankY, angle);
    end

    // Reset landing while the FSM is in MOVE aborts the sequence.
    fwd = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1;
    check_outputs("abort", 160, 240, 0, 0, 64);
    check("abort upd_done", int'(upd_done), 0);
    Reset = 1'b0;
    fwd = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (upd_done) seen++;
    end
    check("abort later upd_done count", seen, 0);
    check("abort TankY hold", int'(TankY), 240);
    $display("abort: TankX=%0d TankY=%0d angle=%0d", TankX, TankY, angle);
    do_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_outputs("post-abort", 160, 238, 0, 0, 64);
    $display("post-abort: TankX=%0d TankY=%0d", TankX, TankY);

`ifdef TANK_COLLIDE_EN
    wall_hit = 1'b1;
    do_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_outputs("wall_hit", 160, 238, 0, 0, 64);
    wall_hit = 1'b0;
    $display("wall_hit: TankX=%0d TankY=%0d", TankX, TankY);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
